d_latch_bank: RTL
=================

// Module: d_latch_bank
// PURPOSE
//   Multi-channel, clocked successor to the single-channel gated data latch.
//   NUM_CH independent WIDTH-bit channels, each registered on clk, with a startup sequencer
//   that holds all outputs at zero after reset.
//   Three run modes: zero, follow, and hold with double-buffered atomic commit.
//   Sits between free-running datapath sources and consumers that need glitch-free,
//   simultaneously updated data.
// PARAMETERS
//   WIDTH        32  bits per channel
//   NUM_CH       4   number of channels (>=1)
//   STARTUP_CYC  1   clocks after reset release before RUN (>=1; 1 = one-cycle enable delay)
// PORTS
//   clk       in   1             system clock, all state on posedge
//   rst       in   1             asynchronous, active-low reset
//   mode      in   2             00 ZERO, 01 FOLLOW, 10 HOLD, 11 reserved (treated as HOLD)
//   ch_en     in   NUM_CH        per-channel enable / shadow-load strobe
//   commit    in   1             HOLD mode: copy pending shadows to outputs
//   data_in   in   NUM_CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   data_out  out  NUM_CH*WIDTH  registered channel outputs, same packing
//   pending   out  NUM_CH        shadow of channel c loaded, not yet committed
//   ready     out  1             1 in RUN state
// BEHAVIOUR
//   Reset (rst=0, async): data_out=0, shadows=0, pending=0, ready=0.
//     Startup counter is loaded with STARTUP_CYC; FSM goes to STARTUP.
//   FSM STARTUP:
//     - counter decrements each clk; all inputs ignored; outputs stay 0.
//     - When counter reaches 1, the next edge enters RUN; ready=1 from that edge.
//     - With STARTUP_CYC=1, ready rises at the first edge after rst deasserts.
//   FSM RUN:
//     - Stays in RUN until reset. Reset mid-operation aborts everything immediately.
//   Run modes (mode and ch_en sampled at each edge in RUN):
//     ZERO:   data_out<=0, shadows<=0, pending<=0 at that edge.
//     FOLLOW: per channel c, data_out[c] <= ch_en[c] ? data_in[c] : 0; latency 1 clk.
//             pending<=0; commit ignored.
//     HOLD:   data_out holds.
//             - ch_en[c]=1: shadow[c]<=data_in[c], pending[c]<=1.
//             - commit=1: for every c with pending[c]=1 (pre-edge value),
//               data_out[c]<=shadow[c] (pre-edge value), pending[c]<=0.
//               All such channels update on the same edge (atomic).
//             - Same edge, ch_en[c]=1 and commit=1:
//               data_out[c] gets the OLD shadow if pending[c] was 1, else it holds.
//               shadow[c] takes the new data; pending[c] ends 1.
//             - commit with no pending bits: no effect.
//   Mode change:
//     - Leaving HOLD for FOLLOW or ZERO drops uncommitted shadows (pending cleared).
//     - Entering HOLD keeps the current data_out.
//   mode=11 behaves exactly as HOLD.
// CONFIGURATION
//   D_LATCH_BANK_PARITY_EN defined:
//     - Adds output parity_out [NUM_CH].
//     - parity_out[c] = ^data_out[c] (even parity), registered on the same edge as data_out.
//     - Reset value 0.
//   Not defined: port and logic absent; all other behaviour identical.
// TESTING
//   1 Reset/startup, STARTUP_CYC=3, FOLLOW, ch_en=all-1, data_in all 0xA5A5A5A5, release rst
//     -> data_out=0 for 2 edges; ready=1 at edge 3; data_out=0xA5A5A5A5 at edge 4.
//   2 FOLLOW, ch_en=4'b0101, ch0=0x11, ch1=0x22, ch2=0x33, ch3=0x44
//     -> next edge data_out ch0=0x11, ch1=0, ch2=0x33, ch3=0.
//   3 HOLD, load ch1=0xDEAD then ch3=0xBEEF on separate cycles, commit one cycle later
//     -> outputs unchanged until commit edge; then both update on the same edge;
//        pending 4'b1010 -> 0.
//   4 HOLD, ch0 pending=0x1, same edge ch_en[0]=1 with 0x2 and commit=1
//     -> data_out ch0=0x1, pending[0]=1; next commit -> ch0=0x2.
//   5 HOLD with pending=4'b1111, pull rst low mid-cycle
//     -> data_out, pending, ready go 0 immediately without a clock edge; startup restarts.
//   6 PARITY_EN build, FOLLOW, ch0=0x7
//     -> parity_out[0]=1 on the same edge data_out ch0=0x7.

Source files
------------

// File: rtl/d_latch_bank.sv
// d_latch_bank: NUM_CH registered WIDTH-bit channels with startup sequencer and
// ZERO / FOLLOW / HOLD (double-buffered, atomic commit) modes. Optional parity: D_LATCH_BANK_PARITY_EN.
module d_latch_bank #(
  parameter int WIDTH       = 32,
  parameter int NUM_CH      = 4,
  parameter int STARTUP_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      commit,
  input  logic [NUM_CH*WIDTH-1:0]   data_in,
  output logic [NUM_CH*WIDTH-1:0]   data_out,
  output logic [NUM_CH-1:0]         pending,
  output logic                      ready
`ifdef D_LATCH_BANK_PARITY_EN
  ,
  output logic [NUM_CH-1:0]         parity_out
`endif
);

  localparam int CNT_W = $clog2(STARTUP_CYC + 1);

  typedef enum logic {ST_STARTUP, ST_RUN} state_t;
  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_FOLLOW = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [NUM_CH*WIDTH-1:0]   shadow, shadow_nxt, dout_nxt;
  logic [NUM_CH-1:0]         pending_nxt;

  // ---------------- startup sequencer ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_STARTUP;
      cnt   <= CNT_W'(STARTUP_CYC);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every comb output gets a default first; otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_STARTUP) begin
      if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
      else                  cnt_nxt   = cnt - CNT_W'(1);
    end
  end

  always_comb begin
    ready = (state == ST_RUN);
  end

  // ---------------- channel datapath ----------------
  always_comb begin
    dout_nxt    = data_out;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (ready) begin
      case (mode_t'(mode))
        MODE_ZERO: begin
          dout_nxt    = '0;
          shadow_nxt  = '0;
          pending_nxt = '0;
        end
        MODE_FOLLOW: begin
          // Uncommitted shadows are dropped on leaving HOLD.
          pending_nxt = '0;
          for (int c = 0; c < NUM_CH; c++)
            dout_nxt[c*WIDTH +: WIDTH] = ch_en[c] ? data_in[c*WIDTH +: WIDTH] : '0;
        end
        default: begin
          // HOLD and reserved: commit moves the pre-edge shadow; a same-edge load re-arms pending.
          for (int c = 0; c < NUM_CH; c++) begin
            if (commit && pending[c])
              dout_nxt[c*WIDTH +: WIDTH] = shadow[c*WIDTH +: WIDTH];
            if (ch_en[c]) begin
              shadow_nxt[c*WIDTH +: WIDTH] = data_in[c*WIDTH +: WIDTH];
              pending_nxt[c]               = 1'b1;
            end else if (commit) begin
              pending_nxt[c] = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // NOTE: the shadow store is reset explicitly, since its contents become visible through commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      shadow   <= '0;
      pending  <= '0;
    end else begin
      data_out <= dout_nxt;
      shadow   <= shadow_nxt;
      pending  <= pending_nxt;
    end
  end

`ifdef D_LATCH_BANK_PARITY_EN
  logic [NUM_CH-1:0] parity_nxt;

  always_comb begin
    parity_nxt = '0;
    for (int c = 0; c < NUM_CH; c++)
      parity_nxt[c] = ^dout_nxt[c*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_out <= '0;
    else      parity_out <= parity_nxt;
  end
`endif

endmodule
